// File: rtl/mux_select_arbiter.sv
// ----------------------------------------------------------------------------
// mux_select_arbiter
//   Round-robin arbiter that shares one 8:1 datapath mux among 8 requesters.
//   grant_idx drives the mux select directly. grant_valid qualifies the
//   muxed data. The grant stays with its owner until the owner drops its
//   request, so multi-cycle transfers are never cut short.
//
// Parameters
//   MAX_HOLD     consecutive grant cycles before a forced preemption (2..255).
//                Only used when ARB_HOLD_TIMEOUT_EN is defined.
//
// Configuration macro
//   ARB_HOLD_TIMEOUT_EN  builds the hold counter and the timeout preemption.
//                        When undefined, preempt is tied low.
//
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   arb_en       in   1 = new grants may be issued
//   req[7:0]     in   request vector, held for the whole transaction
//   grant[7:0]   out  registered one-hot grant, zero when idle
//   grant_idx    out  binary owner index (mux select), held while idle
//   grant_valid  out  grant != 0
//   preempt      out  one-cycle pulse on a grant won by timeout preemption
// ----------------------------------------------------------------------------
module mux_select_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       arb_en,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_valid,
    output logic       preempt
);

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_e;

    state_e             state_q,     state_d;
    logic [N_REQ-1:0]   grant_q,     grant_d;
    logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0]   last_idx_q,  last_idx_d;
    logic               preempt_q,   preempt_d;

    // Round-robin search result
    logic [N_REQ-1:0]   cand;
    logic [IDX_W-1:0]   probe;
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;

    // Control decoded by the FSM, consumed by the hold counter
    logic               take_grant;
    logic               hold_grant;
    logic               timeout;

    // ------------------------------------------------------------------------
    // Winner search: first set candidate bit starting at last_idx+1, wrapping.
    // While owned, the owner's own bit is masked so a timeout search only
    // sees other requesters; on release its bit is already low anyway.
    // ------------------------------------------------------------------------
    always_comb begin
        cand      = (state_q == ST_OWN) ? (req & ~grant_q) : req;
        win_found = 1'b0;
        win_idx   = last_idx_q;
        probe     = last_idx_q;
        for (int k = 0; k < N_REQ; k++) begin
            // k+1 == 8 truncates to 0, so the last probe is last_idx itself
            probe = last_idx_q + IDX_W'(k + 1);
            if (!win_found && cand[probe]) begin
                win_found = 1'b1;
                win_idx   = probe;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Hold-time counter and timeout (optional)
    // ------------------------------------------------------------------------
`ifdef ARB_HOLD_TIMEOUT_EN
    logic [7:0] hold_cnt_q, hold_cnt_d;

    // ">=" rather than "==": the counter keeps running past the threshold
    // while the owner is alone, so a requester that shows up later must
    // still be able to force a handover.
    assign timeout = (hold_cnt_q >= 8'(MAX_HOLD - 1));

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (take_grant) begin
            hold_cnt_d = 8'd0;
        end else if (hold_grant && (hold_cnt_q != 8'hFF)) begin
            hold_cnt_d = hold_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= 8'd0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`else
    logic [7:0] unused_max_hold;
    logic       unused_hold_grant;

    assign timeout           = 1'b0;
    assign unused_max_hold   = 8'(MAX_HOLD);
    assign unused_hold_grant = hold_grant;
`endif

    // ------------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        last_idx_d  = last_idx_q;
        preempt_d   = 1'b0;
        take_grant  = 1'b0;
        hold_grant  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (arb_en && win_found) begin
                    take_grant = 1'b1;
                end
            end
            ST_OWN: begin
                if (!req[grant_idx_q]) begin
                    // Release: hand over at this same edge if possible
                    if (arb_en && win_found) begin
                        take_grant = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                    end
                end else if (timeout && arb_en && win_found) begin
                    take_grant = 1'b1;
                    preempt_d  = 1'b1;
                end else begin
                    hold_grant = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase

        if (take_grant) begin
            state_d          = ST_OWN;
            grant_d          = '0;
            grant_d[win_idx] = 1'b1;
            grant_idx_d      = win_idx;
            last_idx_d       = win_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            last_idx_q  <= IDX_W'(N_REQ - 1);   // first search starts at 0
            preempt_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            last_idx_q  <= last_idx_d;
            preempt_q   <= preempt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = grant_idx_q;
    assign grant_valid = (state_q == ST_OWN);
    assign preempt     = preempt_q;

endmodule

// File: tb/tb_mux_select_arbiter.sv
module tb_mux_select_arbiter;

    logic       clk;
    logic       rst_n;
    logic       arb_en;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       preempt;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [7:0] g;
        logic [2:0] idx;
        logic       v;
        logic       p;
    } exp_t;

    typedef struct packed {
        logic       en;
        logic [7:0] rq;
        logic [7:0] g;
        logic [2:0] idx;
        logic       p;
    } step_t;

    exp_t sb[$];

    mux_select_arbiter #(.MAX_HOLD(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .arb_en      (arb_en),
        .req         (req),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .preempt     (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(logic [7:0] g, logic [2:0] i, logic p);
        exp_t e;
        e.g   = g;
        e.idx = i;
        e.v   = (g != 8'h00);
        e.p   = p;
        return e;
    endfunction

    function automatic exp_t obs();
        exp_t e;
        e.g   = grant;
        e.idx = grant_idx;
        e.v   = grant_valid;
        e.p   = preempt;
        return e;
    endfunction

    function automatic step_t st(logic en, logic [7:0] rq, logic [7:0] g, logic [2:0] i, logic p);
        step_t s;
        s.en  = en;
        s.rq  = rq;
        s.g   = g;
        s.idx = i;
        s.p   = p;
        return s;
    endfunction

    // Structural invariants, checked every cycle outside reset
    always @(negedge clk) begin
        if (rst_n) begin
            n_chk++;
            if ((grant_valid !== (grant != 8'h00)) || ($countones(grant) > 1) ||
                (grant_valid && (grant !== (8'h01 << grant_idx)))) begin
                n_fail++;
                $display("FAIL invariant t=%0t: grant=%h idx=%0d valid=%b", $time, grant, grant_idx, grant_valid);
            end
        end
    end

    task automatic test_reset();
        exp_t got, want;
        rst_n  = 1'b0;
        arb_en = 1'b1;
        req    = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        sb.push_back(mk(8'h00, 3'd0, 1'b0));
        got = obs(); want = sb.pop_front(); n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL reset_state: got %h/%0d/%b/%b want %h/%0d/%b/%b", got.g, got.idx, got.v, got.p, want.g, want.idx, want.v, want.p);
        end
        rst_n = 1'b1;
        req   = 8'h04;
        sb.push_back(mk(8'h04, 3'd2, 1'b0));
        @(posedge clk); #1;
        got = obs(); want = sb.pop_front(); n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL reset_grant04: got %h/%0d/%b/%b want %h/%0d/%b/%b", got.g, got.idx, got.v, got.p, want.g, want.idx, want.v, want.p);
        end
        // Asynchronous reset in the middle of a grant
        rst_n = 1'b0;
        sb.push_back(mk(8'h00, 3'd0, 1'b0));
        #1;
        got = obs(); want = sb.pop_front(); n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL reset_midgrant: got %h/%0d/%b/%b want %h/%0d/%b/%b", got.g, got.idx, got.v, got.p, want.g, want.idx, want.v, want.p);
        end
        rst_n = 1'b1;
        req   = 8'h01;
        sb.push_back(mk(8'h01, 3'd0, 1'b0));
        @(posedge clk); #1;
        got = obs(); want = sb.pop_front(); n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL reset_first01: got %h/%0d/%b/%b want %h/%0d/%b/%b", got.g, got.idx, got.v, got.p, want.g, want.idx, want.v, want.p);
        end
        req = 8'h00;
        sb.push_back(mk(8'h00, 3'd0, 1'b0));
        @(posedge clk); #1;
        got = obs(); want = sb.pop_front(); n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL reset_idle: got %h/%0d/%b/%b want %h/%0d/%b/%b", got.g, got.idx, got.v, got.p, want.g, want.idx, want.v, want.p);
        end
    endtask

    task automatic test_handover();
        step_t s[$];
        exp_t  got, want;
        s.push_back(st(1, 8'h01, 8'h01, 3'd0, 0));
        s.push_back(st(1, 8'h85, 8'h01, 3'd0, 0));
        s.push_back(st(1, 8'h84, 8'h04, 3'd2, 0));
        s.push_back(st(1, 8'h80, 8'h80, 3'd7, 0));
        s.push_back(st(1, 8'h00, 8'h00, 3'd7, 0));
        foreach (s[i]) begin
            arb_en = s[i].en; req = s[i].rq;
            sb.push_back(mk(s[i].g, s[i].idx, s[i].p));
            @(posedge clk); #1;
            got = obs(); want = sb.pop_front(); n_chk++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL handover step %0d: got %h/%0d/%b/%b want %h/%0d/%b/%b", i, got.g, got.idx, got.v, got.p, want.g, want.idx, want.v, want.p);
            end
        end
    endtask

    task automatic test_wrap_fairness();
        step_t s[$];
        exp_t  got, want;
        s.push_back(st(1, 8'h81, 8'h01, 3'd0, 0));   // last_idx=7 -> bit 0 first
        s.push_back(st(1, 8'h80, 8'h80, 3'd7, 0));
        s.push_back(st(1, 8'h81, 8'h80, 3'd7, 0));
        s.push_back(st(1, 8'h01, 8'h01, 3'd0, 0));
        s.push_back(st(1, 8'h07, 8'h01, 3'd0, 0));
        s.push_back(st(1, 8'h06, 8'h02, 3'd1, 0));
        s.push_back(st(1, 8'h07, 8'h02, 3'd1, 0));   // 0 re-requests
        s.push_back(st(1, 8'h05, 8'h04, 3'd2, 0));   // 2 goes before 0
        s.push_back(st(1, 8'h01, 8'h01, 3'd0, 0));
        s.push_back(st(1, 8'h00, 8'h00, 3'd0, 0));
        foreach (s[i]) begin
            arb_en = s[i].en; req = s[i].rq;
            sb.push_back(mk(s[i].g, s[i].idx, s[i].p));
            @(posedge clk); #1;
            got = obs(); want = sb.pop_front(); n_chk++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL wrap step %0d: got %h/%0d/%b/%b want %h/%0d/%b/%b", i, got.g, got.idx, got.v, got.p, want.g, want.idx, want.v, want.p);
            end
        end
    endtask

    task automatic test_enable();
        step_t s[$];
        exp_t  got, want;
        repeat (5) s.push_back(st(0, 8'h02, 8'h00, 3'd0, 0));
        s.push_back(st(1, 8'h02, 8'h02, 3'd1, 0));
        s.push_back(st(0, 8'h06, 8'h02, 3'd1, 0));
        s.push_back(st(0, 8'h06, 8'h02, 3'd1, 0));
        s.push_back(st(0, 8'h04, 8'h00, 3'd1, 0));   // release with arb_en=0 -> idle
        s.push_back(st(1, 8'h00, 8'h00, 3'd1, 0));
        s.push_back(st(1, 8'h02, 8'h02, 3'd1, 0));
        s.push_back(st(1, 8'h0A, 8'h02, 3'd1, 0));   // bit 3 glitch
        s.push_back(st(1, 8'h02, 8'h02, 3'd1, 0));
        s.push_back(st(1, 8'h00, 8'h00, 3'd1, 0));
        foreach (s[i]) begin
            arb_en = s[i].en; req = s[i].rq;
            sb.push_back(mk(s[i].g, s[i].idx, s[i].p));
            @(posedge clk); #1;
            got = obs(); want = sb.pop_front(); n_chk++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL enable step %0d: got %h/%0d/%b/%b want %h/%0d/%b/%b", i, got.g, got.idx, got.v, got.p, want.g, want.idx, want.v, want.p);
            end
        end
    endtask

    task automatic test_timeout();
        step_t s[$];
        exp_t  got, want;
`ifdef ARB_HOLD_TIMEOUT_EN
        repeat (4) s.push_back(st(1, 8'h03, 8'h01, 3'd0, 0));
        s.push_back(st(1, 8'h03, 8'h02, 3'd1, 1));
        repeat (3) s.push_back(st(1, 8'h03, 8'h02, 3'd1, 0));
        s.push_back(st(1, 8'h03, 8'h01, 3'd0, 1));
        s.push_back(st(1, 8'h03, 8'h01, 3'd0, 0));
`else
        repeat (10) s.push_back(st(1, 8'h03, 8'h01, 3'd0, 0));
`endif
        s.push_back(st(1, 8'h00, 8'h00, 3'd0, 0));
        foreach (s[i]) begin
            arb_en = s[i].en; req = s[i].rq;
            sb.push_back(mk(s[i].g, s[i].idx, s[i].p));
            @(posedge clk); #1;
            got = obs(); want = sb.pop_front(); n_chk++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL timeout step %0d: got %h/%0d/%b/%b want %h/%0d/%b/%b", i, got.g, got.idx, got.v, got.p, want.g, want.idx, want.v, want.p);
            end
        end
    endtask

    task automatic test_sole_owner();
        step_t s[$];
        exp_t  got, want;
        repeat (20) s.push_back(st(1, 8'h10, 8'h10, 3'd4, 0));
        s.push_back(st(1, 8'h00, 8'h00, 3'd4, 0));
        foreach (s[i]) begin
            arb_en = s[i].en; req = s[i].rq;
            sb.push_back(mk(s[i].g, s[i].idx, s[i].p));
            @(posedge clk); #1;
            got = obs(); want = sb.pop_front(); n_chk++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL sole step %0d: got %h/%0d/%b/%b want %h/%0d/%b/%b", i, got.g, got.idx, got.v, got.p, want.g, want.idx, want.v, want.p);
            end
        end
    endtask

    initial begin
        test_reset();
        test_handover();
        test_wrap_fairness();
        test_enable();
        test_timeout();
        test_sole_owner();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
